// File: rtl/alu_issue_ctrl.sv
// Sequential initiator for a combinational ALU: launches registered operands,
// waits a fixed settle window, captures result/flags and returns them on a valid/ready channel.
module alu_issue_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carry,
    output logic             resp_ovf,
    output logic             resp_zero,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_cmd_q, alu_cmd_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_carry_q, resp_carry_d;
    logic             resp_ovf_q, resp_ovf_d;
    logic             resp_zero_q, resp_zero_d;
    logic             arith_cmd;

    // Carry and overflow only mean something for the adder commands.
    assign arith_cmd = (alu_cmd_q == CMD_ADD) || (alu_cmd_q == CMD_SUB);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cmd_d     = alu_cmd_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_carry_d  = resp_carry_q;
        resp_ovf_d    = resp_ovf_q;
        resp_zero_d   = resp_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_cmd_d = req_cmd;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    resp_result_d = alu_result;
                    resp_carry_d  = arith_cmd & alu_carryout;
                    resp_ovf_d    = arith_cmd & alu_overflow;
                    resp_zero_d   = (alu_result == '0);
                    resp_valid_d  = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cmd_q     <= 3'd0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_ovf_q    <= 1'b0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cmd_q     <= alu_cmd_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_carry_q  <= resp_carry_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cmd     = alu_cmd_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign resp_ovf    = resp_ovf_q;
    assign resp_zero   = resp_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached to its ALU port.
module tb_alu_issue_ctrl;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   req_cmd;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_cmd;
    logic [W-1:0] alu_result;
    logic         alu_carryout;
    logic         alu_overflow;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_carry;
    logic         resp_ovf;
    logic         resp_zero;
    logic         busy;
    logic [W-1:0] alu_noise;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_carry(resp_carry), .resp_ovf(resp_ovf),
        .resp_zero(resp_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-level ALU; raw adder flags are driven for every command so masking is visible.
    logic [W:0]   add_w;
    logic [W:0]   sub_w;
    logic [W-1:0] alu_r;
    always_comb begin
        add_w = {1'b0, alu_a} + {1'b0, alu_b};
        sub_w = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_r = '0;
        case (alu_cmd)
            3'd0: alu_r = add_w[W-1:0];
            3'd1: alu_r = sub_w[W-1:0];
            3'd2: alu_r = alu_a ^ alu_b;
            3'd3: alu_r = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            3'd4: alu_r = alu_a & alu_b;
            3'd5: alu_r = ~(alu_a & alu_b);
            3'd6: alu_r = ~(alu_a | alu_b);
            default: alu_r = alu_a | alu_b;
        endcase
        alu_result = alu_r ^ alu_noise;
        if (alu_cmd == 3'd1) begin
            alu_carryout = sub_w[W] ^ alu_noise[0];
            alu_overflow = ((alu_a[W-1] != alu_b[W-1]) && (sub_w[W-1] != alu_a[W-1])) ^ alu_noise[1];
        end else begin
            alu_carryout = add_w[W] ^ alu_noise[0];
            alu_overflow = ((alu_a[W-1] == alu_b[W-1]) && (add_w[W-1] != alu_a[W-1])) ^ alu_noise[1];
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cmd);
        exp_t e;
        longint sa;
        longint sb;
        longint s;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e  = '0;
        case (cmd)
            3'd0: begin
                s     = sa + sb;
                e.res = W'(ua + ub);
                e.c   = ((ua + ub) >> 32) != 0;
                e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                s     = sa - sb;
                e.res = W'(ua - ub);
                e.c   = (ua >= ub);
                e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: e.res = a ^ b;
            3'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: e.res = a & b;
            3'd5: e.res = ~(a & b);
            3'd6: e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cmd,
                         input int hold, input bit stress);
        exp_t e;
        int   lat;
        sb_q.push_back(model(a, b, cmd));
        check_eq("req_ready_idle", W'(req_ready), 1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_cmd   = cmd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        check_eq("alu_a_launch", alu_a, a);
        check_eq("alu_cmd_launch", W'(alu_cmd), W'(cmd));
        check_eq("busy_settle", W'(busy), 1);
        lat = 0;
        while (!resp_valid && lat < S + 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", W'(lat), W'(S));
        e = sb_q.pop_front();
        check_eq("result", resp_result, e.res);
        check_eq("carry", W'(resp_carry), W'(e.c));
        check_eq("ovf", W'(resp_ovf), W'(e.o));
        check_eq("zero", W'(resp_zero), W'(e.z));
        for (int i = 0; i < hold; i++) begin
            if (stress) begin
                req_valid = 1'($urandom);
                req_a     = $urandom;
                alu_noise = $urandom;
            end
            @(posedge clk); #1;
            if (stress) begin
                check_eq("hold_valid", W'(resp_valid), 1);
                check_eq("hold_result", resp_result, e.res);
                check_eq("hold_flags", W'({resp_carry, resp_ovf, resp_zero}), W'({e.c, e.o, e.z}));
                check_eq("hold_ready", W'(req_ready), 0);
                check_eq("hold_alu_a", alu_a, a);
            end
        end
        req_valid  = 1'b0;
        alu_noise  = '0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq("resp_cleared", W'(resp_valid), 0);
        check_eq("busy_idle", W'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_cmd    = 3'd0;
        resp_ready = 1'b0;
        alu_noise  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", W'(busy), 0);
        check_eq("rst_req_ready", W'(req_ready), 1);
        check_eq("rst_resp_valid", W'(resp_valid), 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_resp_result", resp_result, 0);
        reset = 1'b0;

        do_op(32'd5, 32'd7, 3'd0, 0, 1'b0);
        do_op(32'd3, 32'd5, 3'd1, 1, 1'b0);
        do_op(32'd5, 32'd3, 3'd1, 0, 1'b0);
        do_op(32'd9, 32'd9, 3'd1, 2, 1'b0);
        do_op(32'h7FFFFFFF, 32'd1, 3'd0, 0, 1'b0);
        do_op(32'h7FFFFFFF, 32'd1, 3'd2, 0, 1'b0);
        do_op(32'hFFFFFFFF, 32'd1, 3'd3, 0, 1'b0);
        do_op(32'd1, 32'hFFFFFFFF, 3'd3, 0, 1'b0);
        do_op(32'hFFFFFFFF, 32'd1, 3'd0, 0, 1'b0);
        do_op(32'hFFFFFFFF, 32'd1, 3'd4, 0, 1'b0);
        do_op(32'h80000000, 32'd1, 3'd1, 0, 1'b0);
        do_op(32'hF0F0A5A5, 32'h0FF0FFFF, 3'd5, 0, 1'b0);
        do_op(32'hF0F0A5A5, 32'h0FF00000, 3'd6, 0, 1'b0);
        do_op(32'hF0F00000, 32'h0000A5A5, 3'd7, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_op($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 2), 1'b0);
        end

        do_op(32'h12345678, 32'h11111111, 3'd1, 10, 1'b1);

        // Reset two cycles into the settle window drops the op.
        req_valid = 1'b1;
        req_a     = 32'hDEADBEEF;
        req_b     = 32'h00000001;
        req_cmd   = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_settle_busy", W'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst2_busy", W'(busy), 0);
        check_eq("rst2_resp_valid", W'(resp_valid), 0);
        check_eq("rst2_alu_a", alu_a, 0);
        check_eq("rst2_alu_b", alu_b, 0);
        check_eq("rst2_alu_cmd", W'(alu_cmd), 0);
        repeat (S + 3) @(posedge clk);
        #1;
        check_eq("dropped_no_resp", W'(resp_valid), 0);

        do_op(32'd100, 32'd23, 3'd0, 0, 1'b0);
        check_eq("sb_empty", W'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
